audio_gain_stage: RTL and testbench

- Stereo volume/mute stage between the I2S receive FIFO read side and the I2S transmit FIFO write side of the audio loopback path. It replaces the direct ADC-to-DAC FIFO copy.
- Per sample word it performs: pop from ADC FIFO, apply a per-channel Q2.14 gain with rounding and saturation, push to DAC FIFO.
- Single system clock domain; both FIFOs are dual-clock, so this block never sees bclk.

---
 rtl/audio_pkg.sv | 24 ++
 rtl/audio_gain_mul_sat.sv | 32 +++
 rtl/audio_gain_stage.sv | 141 ++++++++++++++
 tb/tb_audio_gain_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants, FSM encoding and stereo word slicing for the audio gain stage.
package audio_pkg;

    localparam logic [15:0]        GAIN_UNITY = 16'h4000;
    localparam logic signed [15:0] SAMPLE_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_MUL  = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    function automatic logic signed [15:0] left_of(input logic [31:0] word);
        return $signed(word[31:16]);
    endfunction

    function automatic logic signed [15:0] right_of(input logic [31:0] word);
        return $signed(word[15:0]);
    endfunction

endpackage

// File: rtl/audio_gain_mul_sat.sv
// One channel of Q2.14 gain: signed multiply, round half up, shift by 14, clip to sample range.
// Purely combinational; clip is high whenever the result had to be clamped.
module audio_gain_mul_sat #(
    parameter int SW = 16,
    parameter int GW = 16
) (
    input  logic signed [SW-1:0] sample,
    input  logic        [GW-1:0] gain,
    output logic signed [SW-1:0] result,
    output logic                 clip
);
    localparam int PW = SW + GW + 1;
    localparam logic signed [PW-1:0] HALF_LSB = PW'(1) <<< (GW - 3);

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    logic        [PW-SW:0] hi;

    always_comb begin
        prod    = sample * $signed({1'b0, gain});
        shifted = (prod + HALF_LSB) >>> (GW - 2);
        // In range only if every bit above the output sign bit matches it.
        hi      = shifted[PW-1:SW-1];
        clip    = !((&hi) || (~|hi));
        if (clip) begin
            result = shifted[PW-1] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
        end else begin
            result = shifted[SW-1:0];
        end
    end

endmodule

// File: rtl/audio_gain_stage.sv
// Stereo volume/mute stage: pop ADC FIFO, apply per-channel Q2.14 gain, push DAC FIFO.
// Define AUDIO_GAIN_SOFT_RAMP_EN for a per-sample gain ramp with fade-in from zero after reset.
module audio_gain_stage
    import audio_pkg::*;
#(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   GAIN_WIDTH = 16,
    parameter logic [GAIN_WIDTH-1:0] RAMP_STEP = 16'd64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [GAIN_WIDTH-1:0] gain_l,
    input  logic [GAIN_WIDTH-1:0] gain_r,
    input  logic                  mute,
    input  logic                  adcfifo_empty,
    output logic                  adcfifo_read,
    input  logic [DATA_WIDTH-1:0] adcfifo_readdata,
    input  logic                  dacfifo_full,
    output logic                  dacfifo_write,
    output logic [DATA_WIDTH-1:0] dacfifo_writedata,
    output logic                  sat_flag,
    input  logic                  sat_clr,
    output logic                  busy
);
    localparam int SW = DATA_WIDTH / 2;

`ifdef AUDIO_GAIN_SOFT_RAMP_EN
    localparam logic [GAIN_WIDTH-1:0] RESET_GAIN = '0;
`else
    localparam logic [GAIN_WIDTH-1:0] RESET_GAIN = GAIN_UNITY;
`endif

    state_t                  state_q, state_d;
    logic signed [SW-1:0]    l_in, r_in;
    logic signed [SW-1:0]    res_l, res_r;
    logic                    clip_l, clip_r;
    logic [GAIN_WIDTH-1:0]   cur_gain_l, cur_gain_r;
    logic [GAIN_WIDTH-1:0]   mul_gain_l, mul_gain_r;
    logic [GAIN_WIDTH-1:0]   tgt_l, tgt_r;

    assign tgt_l = mute ? '0 : gain_l;
    assign tgt_r = mute ? '0 : gain_r;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!adcfifo_empty) state_d = ST_RD;
            ST_RD:   state_d = ST_CAP;
            ST_CAP:  state_d = ST_MUL;
            ST_MUL:  state_d = ST_OUT;
            ST_OUT:  if (!dacfifo_full) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign adcfifo_read  = (state_q == ST_RD);
    assign dacfifo_write = (state_q == ST_OUT) && !dacfifo_full;
    assign busy          = (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            l_in              <= '0;
            r_in              <= '0;
            dacfifo_writedata <= '0;
            sat_flag          <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CAP) begin
                l_in <= left_of(adcfifo_readdata);
                r_in <= right_of(adcfifo_readdata);
            end
            if (state_q == ST_MUL) begin
                dacfifo_writedata <= {res_l, res_r};
            end
            if ((state_q == ST_MUL) && (clip_l || clip_r)) begin
                sat_flag <= 1'b1;
            end else if (sat_clr) begin
                sat_flag <= 1'b0;
            end
        end
    end

`ifdef AUDIO_GAIN_SOFT_RAMP_EN
    function automatic logic [GAIN_WIDTH-1:0] step_toward(
        input logic [GAIN_WIDTH-1:0] cur,
        input logic [GAIN_WIDTH-1:0] tgt
    );
        if (cur < tgt) begin
            return ((tgt - cur) > RAMP_STEP) ? cur + RAMP_STEP : tgt;
        end else if (cur > tgt) begin
            return ((cur - tgt) > RAMP_STEP) ? cur - RAMP_STEP : tgt;
        end
        return tgt;
    endfunction

    // A word is scaled by the gain held before its own step, so the first
    // word after reset comes out silent and the ramp lands on target cleanly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_gain_l <= RESET_GAIN;
            cur_gain_r <= RESET_GAIN;
            mul_gain_l <= RESET_GAIN;
            mul_gain_r <= RESET_GAIN;
        end else if (state_q == ST_CAP) begin
            mul_gain_l <= cur_gain_l;
            mul_gain_r <= cur_gain_r;
            cur_gain_l <= step_toward(cur_gain_l, tgt_l);
            cur_gain_r <= step_toward(cur_gain_r, tgt_r);
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_gain_l <= RESET_GAIN;
            cur_gain_r <= RESET_GAIN;
        end else if (state_q == ST_CAP) begin
            cur_gain_l <= tgt_l;
            cur_gain_r <= tgt_r;
        end
    end

    assign mul_gain_l = cur_gain_l;
    assign mul_gain_r = cur_gain_r;
`endif

    audio_gain_mul_sat #(.SW(SW), .GW(GAIN_WIDTH)) u_mul_l (
        .sample (l_in),
        .gain   (mul_gain_l),
        .result (res_l),
        .clip   (clip_l)
    );

    audio_gain_mul_sat #(.SW(SW), .GW(GAIN_WIDTH)) u_mul_r (
        .sample (r_in),
        .gain   (mul_gain_r),
        .result (res_r),
        .clip   (clip_r)
    );

endmodule

// File: tb/tb_audio_gain_stage.sv
// Directed plus randomized bench for audio_gain_stage with FIFO models and an arithmetic reference.
module tb_audio_gain_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] gain_l = 16'h4000;
    logic [15:0] gain_r = 16'h4000;
    logic        mute = 1'b0;
    logic        adcfifo_empty = 1'b1;
    logic        adcfifo_read;
    logic [31:0] adcfifo_readdata = '0;
    logic        dacfifo_full = 1'b0;
    logic        dacfifo_write;
    logic [31:0] dacfifo_writedata;
    logic        sat_flag;
    logic        sat_clr = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    audio_gain_stage dut (
        .clk               (clk),
        .reset             (reset),
        .gain_l            (gain_l),
        .gain_r            (gain_r),
        .mute              (mute),
        .adcfifo_empty     (adcfifo_empty),
        .adcfifo_read      (adcfifo_read),
        .adcfifo_readdata  (adcfifo_readdata),
        .dacfifo_full      (dacfifo_full),
        .dacfifo_write     (dacfifo_write),
        .dacfifo_writedata (dacfifo_writedata),
        .sat_flag          (sat_flag),
        .sat_clr           (sat_clr),
        .busy              (busy)
    );

    logic [31:0] adc_q[$];
    logic [31:0] dac_q[$];
    int cyc = 0, rd_cyc = -1, wr_cyc = -1, rd_count = 0;
    int npass = 0, ntotal = 0, nfail = 0;

    // FIFO models observed mid-cycle, clear of the DUT's active edge.
    always @(negedge clk) begin
        cyc++;
        if (adcfifo_read) begin
            rd_cyc = cyc;
            rd_count++;
            if (adc_q.size() > 0) adcfifo_readdata = adc_q.pop_front();
            adcfifo_empty = (adc_q.size() == 0);
        end
        if (dacfifo_write) begin
            wr_cyc = cyc;
            dac_q.push_back(dacfifo_writedata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: gains tracked as plain integers.
    int mg_l, mg_r;

    task automatic model_reset();
`ifdef AUDIO_GAIN_SOFT_RAMP_EN
        mg_l = 0; mg_r = 0;
`else
        mg_l = 16384; mg_r = 16384;
`endif
    endtask

    function automatic logic [15:0] scale(input logic [15:0] x, input int g, inout bit clipped);
        longint p;
        p = longint'($signed(x)) * longint'(g);
        p = (p + 8192) >>> 14;
        if (p > 32767) begin p = 32767; clipped = 1; end
        if (p < -32768) begin p = -32768; clipped = 1; end
        return p[15:0];
    endfunction

    function automatic int ramp(input int cur, input int tgt);
        if (tgt > cur) return (tgt - cur > 64) ? cur + 64 : tgt;
        if (tgt < cur) return (cur - tgt > 64) ? cur - 64 : tgt;
        return tgt;
    endfunction

    task automatic model_next(input logic [31:0] w, output logic [31:0] exp, output bit clipped);
        int tl, tr, ul, ur;
        logic [15:0] hl, hr;
        tl = mute ? 0 : int'(gain_l);
        tr = mute ? 0 : int'(gain_r);
`ifdef AUDIO_GAIN_SOFT_RAMP_EN
        ul = mg_l; ur = mg_r;
        mg_l = ramp(mg_l, tl);
        mg_r = ramp(mg_r, tr);
`else
        ul = tl; ur = tr;
        mg_l = tl; mg_r = tr;
`endif
        clipped = 0;
        hl = w[31:16];
        hr = w[15:0];
        exp = {scale(hl, ul, clipped), scale(hr, ur, clipped)};
    endtask

    task automatic push(input logic [31:0] w);
        @(posedge clk);
        #1;
        adc_q.push_back(w);
        adcfifo_empty = 1'b0;
    endtask

    task automatic wait_dac(input string tag, input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (dac_q.size() >= n) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) check({tag, "_timeout"}, 32'(dac_q.size()), 32'(n));
    endtask

    task automatic run_word(input string tag, input logic [31:0] w, output logic [31:0] got);
        logic [31:0] exp;
        bit clipped, ok;
        model_next(w, exp, clipped);
        push(w);
        wait_dac(tag, 1, ok);
        got = 'x;
        if (ok) begin
            got = dac_q.pop_front();
            check(tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] got, exp1, exp2, held;
        bit clipped, ok;
        int bad, rd0;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {28'd0, adcfifo_read, dacfifo_write, sat_flag, busy}, 32'd0);
        check("reset_writedata", dacfifo_writedata, 32'd0);
        reset = 1'b0;

        // Unity pass-through and latency
        run_word("unity", 32'h1234_EDCB, got);
`ifndef AUDIO_GAIN_SOFT_RAMP_EN
        check("unity_const", got, 32'h1234_EDCB);
`endif
        check("latency", 32'(wr_cyc - rd_cyc), 32'd3);

        // Half gain with rounding
        gain_l = 16'h2000; gain_r = 16'h2000;
        run_word("half", 32'h0003_FFFD, got);
`ifndef AUDIO_GAIN_SOFT_RAMP_EN
        check("half_const", got, 32'h0002_FFFF);
        check("half_noflag", 32'(sat_flag), 32'd0);
`endif

        // Saturation; under ramp the gain is still small so no clip is expected
        gain_l = 16'hFFFF; gain_r = 16'hFFFF;
        run_word("sat", 32'h7000_9000, got);
`ifndef AUDIO_GAIN_SOFT_RAMP_EN
        check("sat_const", got, 32'h7FFF_8000);
        check("sat_flag_set", 32'(sat_flag), 32'd1);
`endif
        @(negedge clk) sat_clr = 1'b1;
        @(negedge clk);
        check("sat_clr", 32'(sat_flag), 32'd0);

        // Clear held while a new clip lands: set must win
        model_next(32'h7FFF_8000, exp1, clipped);
        push(32'h7FFF_8000);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dacfifo_write) begin ok = 1; break; end
        end
        check("clr_vs_set_write_seen", 32'(ok), 32'd1);
        check("clr_vs_set_flag", 32'(sat_flag), 32'(clipped));
        @(negedge clk);
        check("clr_after", 32'(sat_flag), 32'd0);
        sat_clr = 1'b0;
        wait_dac("clr_vs_set_data", 1, ok);
        if (ok) check("clr_vs_set_data", dac_q.pop_front(), exp1);

        // Backpressure
        gain_l = 16'h3000; gain_r = 16'h5000;
        @(negedge clk) dacfifo_full = 1'b1;
        model_next(32'h1111_AAAA, exp1, clipped);
        model_next(32'h8000_7FFF, exp2, clipped);
        push(32'h1111_AAAA);
        push(32'h8000_7FFF);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (adcfifo_read) ok = 1;
        end
        check("bp_first_pop", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        rd0 = rd_count;
        held = dacfifo_writedata;
        check("bp_held_value", held, exp1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dacfifo_write || adcfifo_read || dacfifo_writedata !== held) bad++;
        end
        check("bp_stall_clean", 32'(bad), 32'd0);
        check("bp_no_pop", 32'(rd_count - rd0), 32'd0);
        check("bp_no_write", 32'(dac_q.size()), 32'd0);
        dacfifo_full = 1'b0;
        wait_dac("bp_release", 2, ok);
        if (ok) begin
            check("bp_word1", dac_q.pop_front(), exp1);
            check("bp_word2", dac_q.pop_front(), exp2);
        end
        repeat (5) @(negedge clk);
        check("bp_no_extra", 32'(dac_q.size()), 32'd0);

        // Randomized gains, mute and samples
        for (int n = 0; n < 40; n++) begin
            gain_l = 16'($urandom_range(0, 16'hFFFF));
            gain_r = 16'($urandom_range(0, 16'hFFFF));
            mute   = ($urandom_range(0, 4) == 0);
            run_word("random", $urandom, got);
        end
        mute = 1'b0;

        // Reset while the popped sample is in MUL: it must vanish
        gain_l = 16'hFFFF; gain_r = 16'hFFFF;
        rd0 = rd_count;
        push(32'h7FFF_7FFF);
        for (int i = 0; i < 100 && rd_count == rd0; i++) @(negedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midreset_outputs", {28'd0, adcfifo_read, dacfifo_write, sat_flag, busy}, 32'd0);
        check("midreset_writedata", dacfifo_writedata, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        repeat (20) @(negedge clk);
        check("midreset_no_write", 32'(dac_q.size()), 32'd0);
        gain_l = 16'h4000; gain_r = 16'h4000;
        run_word("midreset_resume", 32'h0102_F0F0, got);

`ifdef AUDIO_GAIN_SOFT_RAMP_EN
        // Fade-in from reset, then fade-out on mute
        do_reset();
        for (int n = 1; n <= 300; n++) begin
            run_word("ramp_up", 32'h4000_4000, got);
            if (n == 1)   check("ramp_first", got, 32'h0000_0000);
            if (n == 2)   check("ramp_second", got, 32'h0040_0040);
            if (n == 257) check("ramp_unity", got, 32'h4000_4000);
        end
        mute = 1'b1;
        for (int n = 1; n <= 260; n++) begin
            run_word("ramp_down", 32'h4000_4000, got);
            if (n == 1)   check("mute_first", got, 32'h4000_4000);
            if (n == 257) check("mute_silent", got, 32'h0000_0000);
        end
        mute = 1'b0;
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
